udp_writer: RTL and testbench
=============================

Name: udp_writer

Overview:
- Byte serializer for the UDP transmit path; the transmit-side counterpart of the receive-side byte unpacker.
- Captures a CAPACITY-byte parallel word on a start pulse and emits it MSB byte first as a valid/ready byte stream with a last flag.
- Feeds the UDP payload input of the Ethernet TX stack.
- Byte order mirrors the receive side: i_data[CAPACITY*8-1 -: 8] is the first byte on the wire.

Parameters:
- CAPACITY, 1, number of payload bytes per word (legal range >= 1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to send i_data.
- i_data  input  CAPACITY*8  word to send; sampled only in the cycle start is accepted.
- busy  output  1  high while a word is being sent (state SEND).
- tx_valid  output  1  tx_data holds a valid byte.
- tx_ready  input  1  downstream accepts the byte this cycle.
- tx_data  output  8  current byte.
- tx_last  output  1  current byte is the final byte of the word; qualified by tx_valid.
- done  output  1  one-cycle pulse in the cycle after the final byte transfers.
- error  output  1  sticky; set when start is rejected, cleared only by rst.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - State goes to IDLE; byte index goes to 0.
  - busy=0, tx_valid=0, tx_data=0, tx_last=0, done=0, error=0.
  - The shift register is cleared to 0.
- Transfer: a byte transfers in a cycle where tx_valid && tx_ready.
- States: IDLE and SEND.
- IDLE:
  - start=1 loads i_data into the shift register, sets byte index to 0, and moves to SEND.
  - tx_valid rises on the next cycle, so latency from start to first tx_valid is 1 cycle.
- SEND:
  - tx_valid=1 and busy=1.
  - tx_data is the byte at index k = CAPACITY-1-idx of the captured word.
  - tx_last = (idx == CAPACITY-1).
  - On each transfer idx increments.
  - On the transfer where tx_last=1:
    - done pulses high in the next cycle.
    - The block returns to IDLE, so tx_valid is 0 in the next cycle, unless a back-to-back start is accepted (see below).
- Stall: while tx_valid=1 and tx_ready=0, tx_data, tx_last and idx hold stable. tx_valid must not drop until the byte transfers.
- Throughput: with tx_ready held high, one byte per cycle. A word takes CAPACITY cycles of tx_valid.
- Back-to-back start: start in the same cycle as the final transfer (tx_last && tx_ready) is accepted.
  - The new i_data is loaded, idx resets to 0, and the block stays in SEND.
  - The first byte of the new word appears on the very next cycle with no idle gap.
  - done still pulses for the completed word.
- Rejected start: start while in SEND and not in a final-transfer cycle is ignored.
  - The word in flight is unaffected.
  - error is set to 1 from the next cycle and stays 1.
- CAPACITY=1: the single byte is presented with tx_last=1; behaviour is otherwise identical.
- Reset mid-word: the word is abandoned with no tx_last and no done. tx_valid is 0 from the cycle after the rst edge.
- Index width: max(1, $clog2(CAPACITY)) bits; it never exceeds CAPACITY-1.
- i_data changes while busy have no effect on output.

Test Plan:
- Basic send: CAPACITY=4, start with i_data=32'hA1B2C3D4, tx_ready=1 -> tx_data A1,B2,C3,D4 on 4 consecutive cycles starting 1 cycle after start; tx_last only with D4; done 1 cycle after the D4 transfer; busy low after.
- Backpressure: CAPACITY=4, tx_ready toggled 1,0,0,1,0,1,1 -> each byte held stable while stalled; exactly 4 transfers in order A1..D4; tx_valid never drops mid-word.
- Back-to-back: start with 32'h01020304, then start with 32'h0A0B0C0D in the D4-equivalent (04) transfer cycle -> stream 01,02,03,04,0A,0B,0C,0D with no gap; done pulses after 04 and after 0D; error stays 0.
- Rejected start: start with 32'h11223344, then start with 32'hFFFFFFFF while the second byte is stalled -> output still 11,22,33,44; error=1 from the next cycle and held until rst.
- Reset mid-word: rst high after 2 of 4 bytes transfer -> next cycle tx_valid=0, busy=0, error=0, no done; a subsequent start with 32'h55667788 sends 55,66,77,88 correctly.
- CAPACITY=1: start with 8'h5A -> single cycle tx_valid=1, tx_data=5A, tx_last=1; done next cycle.

Source files
------------

// File: rtl/udp_writer_if.sv
// Byte-stream bus between a word source and the UDP payload serializer.
// The master side owns start/i_data/tx_ready; the serializer is the slave.
interface udp_writer_if #(
  parameter int CAPACITY = 1
);
  logic                  start;
  logic [CAPACITY*8-1:0] i_data;
  logic                  busy;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [7:0]            tx_data;
  logic                  tx_last;
  logic                  done;
  logic                  error;

  modport master (
    output start, i_data, tx_ready,
    input  busy, tx_valid, tx_data, tx_last, done, error
  );

  modport slave (
    input  start, i_data, tx_ready,
    output busy, tx_valid, tx_data, tx_last, done, error
  );
endinterface

// File: rtl/udp_writer.sv
// UDP payload byte serializer: captures a CAPACITY-byte word on start and
// streams it MSB byte first over a valid/ready byte interface with a last
// flag. A start coinciding with the final byte transfer chains the next
// word without an idle cycle; any other start while sending is rejected
// and latches a sticky error.
module udp_writer #(
  parameter int CAPACITY = 1
) (
  input  logic         clk,
  input  logic         rst,
  udp_writer_if.slave  bus
);
  localparam int WORD_W = CAPACITY * 8;
  localparam int IDX_W  = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CAPACITY - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state;
  state_t              state_n;
  logic [IDX_W-1:0]    idx;
  logic [WORD_W-1:0]   shreg;
  logic                done_r;
  logic                error_r;

  logic                is_last;
  logic                xfer;
  logic                final_xfer;
  logic                load;
  logic                reject;

  // The byte on the wire is always the top byte of the shift register;
  // idx only tracks position so the last byte can be flagged.
  assign is_last    = (idx == LAST_IDX);
  assign xfer       = (state == SEND) && bus.tx_ready;
  assign final_xfer = xfer && is_last;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode, start acceptance/rejection and stream outputs.
  always_comb begin
    state_n      = state;
    load         = 1'b0;
    reject       = 1'b0;
    bus.busy     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        bus.busy     = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = shreg[WORD_W-1 -: 8];
        bus.tx_last  = is_last;
        if (final_xfer) begin
          // Start on the last transfer chains the next word seamlessly.
          if (bus.start) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (bus.start) begin
          reject = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Word capture/shift, byte index, done pulse and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      shreg   <= '0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      done_r <= final_xfer;
      if (reject) begin
        error_r <= 1'b1;
      end
      if (load) begin
        shreg <= bus.i_data;
        idx   <= '0;
      end else if (xfer) begin
        shreg <= shreg << 8;
        // Wrap explicitly so idx never exceeds CAPACITY-1 for
        // non-power-of-two capacities.
        idx   <= is_last ? '0 : idx + IDX_W'(1);
      end
    end
  end

  assign bus.done  = done_r;
  assign bus.error = error_r;
endmodule

// File: tb/tb_udp_writer.sv
// Bench for udp_writer: a 4-byte and a 1-byte instance share clk/rst. A
// transaction-level model (bytes remaining in the current word) predicts
// every output each cycle; scenario tasks compare the recorded trace and
// the observed byte stream against the model and fixed expectations.
module tb_udp_writer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  udp_writer_if #(.CAPACITY(4)) bus4();
  udp_writer_if #(.CAPACITY(1)) bus1();

  udp_writer #(.CAPACITY(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  udp_writer #(.CAPACITY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int errors = 0;
  int checks = 0;

  // Model state per instance (0: CAPACITY=4, 1: CAPACITY=1).
  int          rem   [2];
  logic [31:0] cur   [2];
  logic        mdone [2];
  logic        merr  [2];

  // Trace entry: {valid, busy, last&valid, done, error, data&valid}.
  logic [12:0] obs_q[$];
  logic [12:0] exp_q[$];
  logic        rdy_q[$];
  logic [7:0]  got_q[$];
  int          done_cnt;

  function automatic logic [12:0] pack(input logic v, input logic b,
                                       input logic l, input logic dn,
                                       input logic er, input logic [7:0] d);
    return {v, b, l & v, dn, er, v ? d : 8'h00};
  endfunction

  task automatic clear_trace();
    obs_q.delete(); exp_q.delete(); rdy_q.delete(); got_q.delete();
    done_cnt = 0;
  endtask

  // One clock cycle: drive inputs, record DUT and model outputs, advance model.
  task automatic step(input int sel, input logic st, input logic [31:0] d,
                      input logic rdy, input logic rs);
    logic [12:0] o, e;
    logic [7:0]  eb;
    rst           = rs;
    bus4.start    = (sel == 0) ? st : 1'b0;
    bus4.i_data   = d;
    bus4.tx_ready = (sel == 0) ? rdy : 1'b1;
    bus1.start    = (sel == 1) ? st : 1'b0;
    bus1.i_data   = d[7:0];
    bus1.tx_ready = (sel == 1) ? rdy : 1'b1;
    #1;
    if (sel == 0)
      o = pack(bus4.tx_valid, bus4.busy, bus4.tx_last, bus4.done, bus4.error, bus4.tx_data);
    else
      o = pack(bus1.tx_valid, bus1.busy, bus1.tx_last, bus1.done, bus1.error, bus1.tx_data);
    eb = (rem[sel] > 0) ? 8'(cur[sel] >> (8 * (rem[sel] - 1))) : 8'h00;
    e  = pack(rem[sel] > 0, rem[sel] > 0, rem[sel] == 1, mdone[sel], merr[sel], eb);
    obs_q.push_back(o);
    exp_q.push_back(e);
    rdy_q.push_back(rdy);
    if (o[12] && rdy) got_q.push_back(o[7:0]);
    if (o[9]) done_cnt++;
    for (int k = 0; k < 2; k++) begin
      logic sk, rk, xf, fin;
      int   cap;
      cap = (k == 0) ? 4 : 1;
      sk  = (k == sel) ? st : 1'b0;
      rk  = (k == sel) ? rdy : 1'b1;
      if (rs) begin
        rem[k] = 0; mdone[k] = 1'b0; merr[k] = 1'b0;
      end else begin
        xf  = (rem[k] > 0) && rk;
        fin = xf && (rem[k] == 1);
        mdone[k] = fin;
        if (sk && rem[k] > 0 && !fin) merr[k] = 1'b1;
        if (xf) rem[k]--;
        if (sk && rem[k] == 0) begin
          rem[k] = cap;
          cur[k] = (k == 0) ? d : {24'h0, d[7:0]};
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(0, 1'b0, 32'h0, 1'b1, 1'b1);
    rst = 1'b0;
    checks++; if ({bus4.tx_valid, bus4.busy, bus4.tx_last, bus4.done, bus4.error} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl4: got %b required 00000",
        {bus4.tx_valid, bus4.busy, bus4.tx_last, bus4.done, bus4.error});
    end
    checks++; if (bus4.tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_data4: got %h required 00", bus4.tx_data);
    end
    checks++; if ({bus1.tx_valid, bus1.busy, bus1.tx_last, bus1.done, bus1.error, bus1.tx_data} !== 13'b0) begin
      errors++; $display("FAIL reset_all1: got %b required 0", {bus1.tx_valid, bus1.busy,
        bus1.tx_last, bus1.done, bus1.error, bus1.tx_data});
    end
  endtask

  task automatic test_basic();
    logic [7:0] want[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    clear_trace();
    step(0, 1'b1, 32'hA1B2C3D4, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(0, 1'b0, 32'h0, 1'b1, 1'b0);
    foreach (obs_q[i]) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_trace c%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++; if (got_q.size() != 4) begin
      errors++; $display("FAIL basic_count: got %0d required 4", got_q.size());
    end else foreach (want[i]) begin
      checks++; if (got_q[i] !== want[i]) begin
        errors++; $display("FAIL basic_byte%0d: got %h required %h", i, got_q[i], want[i]);
      end
    end
    checks++; if (obs_q[1][12] !== 1'b1 || obs_q[0][12] !== 1'b0) begin
      errors++; $display("FAIL basic_latency: got valid c0=%b c1=%b required 0 1", obs_q[0][12], obs_q[1][12]);
    end
    checks++; if (obs_q[5][9] !== 1'b1 || obs_q[5][11] !== 1'b0) begin
      errors++; $display("FAIL basic_done: got done=%b busy=%b required 1 0", obs_q[5][9], obs_q[5][11]);
    end
  endtask

  task automatic test_backpressure();
    logic rp[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] want[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    clear_trace();
    step(0, 1'b1, 32'hA1B2C3D4, 1'b1, 1'b0);
    foreach (rp[i]) step(0, 1'b0, 32'h0, rp[i], 1'b0);
    for (int i = 0; i < 3; i++) step(0, 1'b0, 32'h0, 1'b1, 1'b0);
    foreach (obs_q[i]) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_trace c%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i + 1 < obs_q.size(); i++) begin
      if (obs_q[i][12] && !rdy_q[i]) begin
        checks++;
        if ({obs_q[i+1][12], obs_q[i+1][10], obs_q[i+1][7:0]} !== {1'b1, obs_q[i][10], obs_q[i][7:0]}) begin
          errors++; $display("FAIL bp_stable c%0d: got %h required %h", i + 1, obs_q[i+1], obs_q[i]);
        end
      end
    end
    checks++; if (got_q.size() != 4) begin
      errors++; $display("FAIL bp_count: got %0d required 4", got_q.size());
    end else foreach (want[i]) begin
      checks++; if (got_q[i] !== want[i]) begin
        errors++; $display("FAIL bp_byte%0d: got %h required %h", i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want[8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
    clear_trace();
    step(0, 1'b1, 32'h01020304, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(0, 1'b1, 32'h0A0B0C0D, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(0, 1'b0, 32'h0, 1'b1, 1'b0);
    foreach (obs_q[i]) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_trace c%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (obs_q[i][12] !== 1'b1) begin
        errors++; $display("FAIL b2b_gap c%0d: got valid=%b required 1", i, obs_q[i][12]);
      end
    end
    checks++; if (got_q.size() != 8) begin
      errors++; $display("FAIL b2b_count: got %0d required 8", got_q.size());
    end else foreach (want[i]) begin
      checks++; if (got_q[i] !== want[i]) begin
        errors++; $display("FAIL b2b_byte%0d: got %h required %h", i, got_q[i], want[i]);
      end
    end
    checks++; if (done_cnt != 2 || bus4.error !== 1'b0) begin
      errors++; $display("FAIL b2b_done_err: got done=%0d error=%b required 2 0", done_cnt, bus4.error);
    end
  endtask

  task automatic test_rejected();
    logic [7:0] want[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_trace();
    step(0, 1'b1, 32'h11223344, 1'b1, 1'b0);
    step(0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(0, 1'b0, 32'h0, 1'b1, 1'b0);
    foreach (obs_q[i]) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rej_trace c%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++; if (obs_q[3][8] !== 1'b1 || obs_q[2][8] !== 1'b0) begin
      errors++; $display("FAIL rej_error_rise: got c2=%b c3=%b required 0 1", obs_q[2][8], obs_q[3][8]);
    end
    checks++; if (bus4.error !== 1'b1) begin
      errors++; $display("FAIL rej_error_sticky: got %b required 1", bus4.error);
    end
    checks++; if (got_q.size() != 4) begin
      errors++; $display("FAIL rej_count: got %0d required 4", got_q.size());
    end else foreach (want[i]) begin
      checks++; if (got_q[i] !== want[i]) begin
        errors++; $display("FAIL rej_byte%0d: got %h required %h", i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] want[4] = '{8'h55, 8'h66, 8'h77, 8'h88};
    clear_trace();
    step(0, 1'b1, 32'hAABBCCDD, 1'b1, 1'b0);
    step(0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(0, 1'b0, 32'h0, 1'b0, 1'b1);
    rst = 1'b0;
    checks++; if ({bus4.tx_valid, bus4.busy, bus4.error, bus4.done} !== 4'b0) begin
      errors++; $display("FAIL rstmid_state: got %b required 0000",
        {bus4.tx_valid, bus4.busy, bus4.error, bus4.done});
    end
    checks++; if (got_q.size() != 2) begin
      errors++; $display("FAIL rstmid_partial: got %0d bytes required 2", got_q.size());
    end
    clear_trace();
    step(0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(0, 1'b1, 32'h55667788, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(0, 1'b0, 32'h0, 1'b1, 1'b0);
    foreach (obs_q[i]) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rstmid_trace c%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++; if (got_q.size() != 4) begin
      errors++; $display("FAIL rstmid_count: got %0d required 4", got_q.size());
    end else foreach (want[i]) begin
      checks++; if (got_q[i] !== want[i]) begin
        errors++; $display("FAIL rstmid_byte%0d: got %h required %h", i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_cap1();
    clear_trace();
    step(1, 1'b1, 32'h0000005A, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1, 1'b0, 32'h0, 1'b1, 1'b0);
    foreach (obs_q[i]) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL cap1_trace c%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++; if ({obs_q[1][12], obs_q[1][10], obs_q[1][7:0]} !== {1'b1, 1'b1, 8'h5A}) begin
      errors++; $display("FAIL cap1_byte: got v/l/d=%b/%b/%h required 1/1/5a",
        obs_q[1][12], obs_q[1][10], obs_q[1][7:0]);
    end
    checks++; if (obs_q[2][12] !== 1'b0 || obs_q[2][9] !== 1'b1) begin
      errors++; $display("FAIL cap1_done: got valid=%b done=%b required 0 1", obs_q[2][12], obs_q[2][9]);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      clear_trace();
      for (int i = 0; i < 300; i++)
        step(s, $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 2) != 0,
             $urandom_range(0, 99) == 0);
      foreach (obs_q[i]) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_trace c%0d: got %h required %h", s, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    bus4.start = 1'b0; bus4.i_data = '0; bus4.tx_ready = 1'b0;
    bus1.start = 1'b0; bus1.i_data = '0; bus1.tx_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; cur[k] = '0; mdone[k] = 1'b0; merr[k] = 1'b0;
    end
    done_cnt = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_rejected();
    test_reset_mid();
    test_cap1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
